// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner: synchronize, debounce and combine turn/hazard inputs for the tail-light sequencer
//
// Ports:
//   clk        in  rising-edge system clock
//   reset      in  asynchronous active-low reset (0 = reset)
//   left_sw    in  raw left turn switch (asynchronous, bouncy)
//   right_sw   in  raw right turn switch (asynchronous, bouncy)
//   hazard_btn in  raw hazard push-button (asynchronous, bouncy)
//   a          out registered left request (hazard forces high)
//   b          out registered right request (hazard forces high)
//   hazard     out registered hazard-mode status
//
// Build option: define HAZARD_LATCH_EN to make each debounced hazard press
// toggle a latched hazard mode; otherwise hazard follows the held button.
`timescale 1ns/1ps
module turn_signal_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic left_sw,
    input  logic right_sw,
    input  logic hazard_btn,
    output logic a,
    output logic b,
    output logic hazard
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [2:0] raw;
    logic [2:0] st;
    logic       hazard_mode;

    assign raw = {hazard_btn, right_sw, left_sw};

    // channel 0 = left, 1 = right, 2 = hazard
    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sq;
        logic [CW-1:0]          cnt;
        logic                   lvl;
        logic                   s;
        assign s     = sq[SYNC_STAGES-1];
        assign st[i] = lvl;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sq  <= '0;
                cnt <= '0;
                lvl <= 1'b0;
            end else begin
                sq <= {sq[SYNC_STAGES-2:0], raw[i]};
                // any agreement restarts the count, so bounces never accumulate
                if (s == lvl) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    lvl <= s;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_LATCH_EN
    logic st_haz_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_haz_d    <= 1'b0;
            hazard_mode <= 1'b0;
        end else begin
            st_haz_d <= st[2];
            if (st[2] & ~st_haz_d) hazard_mode <= ~hazard_mode;
        end
    end
`else
    assign hazard_mode = st[2];
`endif

    // both switches on without hazard is a conflict: drive neither side
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a      <= 1'b0;
            b      <= 1'b0;
            hazard <= 1'b0;
        end else begin
            a      <= hazard_mode | (st[0] & ~st[1]);
            b      <= hazard_mode | (st[1] & ~st[0]);
            hazard <= hazard_mode;
        end
    end
endmodule
